// File: rtl/softmax_argmax_decoder.sv
// softmax_argmax_decoder: captures a softmax probability vector, scans it one
// class per cycle for the arg-max and presents the result on a valid/ready port.
// Ports: clk, rst (sync, active-high), softmax_in/in_valid (vector capture),
//   result_valid/result_ready (handshake), class_idx, confidence, low_conf,
//   margin (top-1 minus top-2), overrun_err (sticky dropped-vector flag).
// Build option: define SOFTMAX_DECODER_TOP2_MARGIN_EN to track the second-best
//   probability and drive margin; otherwise margin is tied to 0.
module softmax_argmax_decoder #(
    parameter int                N_CLASSES   = 10,
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] CONF_THRESH = 16'h0080
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CLASSES*DATA_W-1:0] softmax_in,
    input  logic                        in_valid,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [3:0]                  class_idx,
    output logic [DATA_W-1:0]           confidence,
    output logic                        low_conf,
    output logic [DATA_W-1:0]           margin,
    output logic                        overrun_err
);

    localparam logic [3:0] LAST_IDX = 4'(N_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t            state;
    logic [DATA_W-1:0] vec_q [N_CLASSES];
    logic [3:0]        count;
    logic [DATA_W-1:0] best_val;
    logic [3:0]        best_idx;

    logic [DATA_W-1:0] x;
    logic              take;
    logic [DATA_W-1:0] nxt_best;
    logic [3:0]        nxt_idx;
    logic              load;

`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
    logic [DATA_W-1:0] second_val;
    logic [DATA_W-1:0] nxt_second;
`endif

    // A new vector is taken when idle, or when the held result is accepted
    // in the same cycle (back-to-back capture).
    assign load = in_valid &&
                  ((state == IDLE) || ((state == OUT) && result_ready));

    // Running arg-max step; strict compare keeps the lower index on ties.
    always_comb begin
        x        = vec_q[count];
        take     = (x > best_val);
        nxt_best = take ? x : best_val;
        nxt_idx  = take ? count : best_idx;
`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
        // An element equal to the best lands in second, so a top tie gives 0.
        nxt_second = take ? best_val
                          : ((x > second_val) ? x : second_val);
`endif
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < N_CLASSES; k++) begin
                vec_q[k] <= softmax_in[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            best_val     <= '0;
            best_idx     <= '0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            confidence   <= '0;
            low_conf     <= 1'b0;
            overrun_err  <= 1'b0;
`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
            second_val   <= '0;
            margin       <= '0;
`endif
        end else begin
            if (load) begin
                count    <= '0;
                best_val <= '0;
                best_idx <= '0;
`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
                second_val <= '0;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) state <= SCAN;
                end
                SCAN: begin
                    if (in_valid) overrun_err <= 1'b1;
                    best_val <= nxt_best;
                    best_idx <= nxt_idx;
`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
                    second_val <= nxt_second;
`endif
                    if (count == LAST_IDX) begin
                        state        <= OUT;
                        result_valid <= 1'b1;
                        class_idx    <= nxt_idx;
                        confidence   <= nxt_best;
                        low_conf     <= (nxt_best < CONF_THRESH);
`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
                        margin       <= nxt_best - nxt_second;
`endif
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        state        <= in_valid ? SCAN : IDLE;
                        result_valid <= 1'b0;
                        class_idx    <= '0;
                        confidence   <= '0;
                        low_conf     <= 1'b0;
`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
                        margin       <= '0;
`endif
                    end else if (in_valid) begin
                        overrun_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SOFTMAX_DECODER_TOP2_MARGIN_EN
    assign margin = '0;
`endif

endmodule

// File: tb/tb_softmax_argmax_decoder.sv
// tb_softmax_argmax_decoder: directed and randomized stimulus for the
// softmax arg-max decoder, checked every cycle against a transaction model.
module tb_softmax_argmax_decoder;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int VW = N * DW;

`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
    localparam logic [15:0] M_BASIC = 16'h0080;
`else
    localparam logic [15:0] M_BASIC = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] softmax_in;
    logic          in_valid;
    logic          result_valid;
    logic          result_ready;
    logic [3:0]    class_idx;
    logic [DW-1:0] confidence;
    logic          low_conf;
    logic [DW-1:0] margin;
    logic          overrun_err;

    always #5 clk = ~clk;

    softmax_argmax_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .softmax_in   (softmax_in),
        .in_valid     (in_valid),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .class_idx    (class_idx),
        .confidence   (confidence),
        .low_conf     (low_conf),
        .margin       (margin),
        .overrun_err  (overrun_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: first index of the maximum; second is the largest of the rest.
    function automatic void ref_result(input logic [VW-1:0] v,
                                       output logic [3:0] idx,
                                       output logic [15:0] best,
                                       output logic [15:0] marg);
        logic [15:0] sec;
        int bi;
        best = '0;
        bi   = 0;
        for (int k = 0; k < N; k++)
            if (v[k*DW +: DW] > best) begin
                best = v[k*DW +: DW];
                bi   = k;
            end
        sec = '0;
        for (int k = 0; k < N; k++)
            if (k != bi && v[k*DW +: DW] > sec) sec = v[k*DW +: DW];
        idx = 4'(bi);
`ifdef SOFTMAX_DECODER_TOP2_MARGIN_EN
        marg = best - sec;
`else
        marg = '0;
`endif
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++)
            v[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                        : 16'($urandom_range(0, 7) * 32);
        return v;
    endfunction

    // Transaction model: a vector is busy from acceptance until its result
    // is handed over; the result appears N cycles after acceptance.
    bit          m_busy, m_hold, m_ovr, m_fresh, m_h0;
    int          m_cyc;
    logic [3:0]  e_idx;
    logic [15:0] e_conf, e_marg;

    always @(posedge clk) begin
        m_h0 = m_hold;
        if (rst) begin
            m_busy  = 1'b0;
            m_hold  = 1'b0;
            m_ovr   = 1'b0;
            m_fresh = 1'b1;
        end else begin
            if (m_busy && !m_h0) begin
                m_cyc--;
                if (m_cyc == 0) begin
                    m_hold  = 1'b1;
                    m_fresh = 1'b0;
                end
            end
            if (m_h0 && result_ready) begin
                m_hold = 1'b0;
                m_busy = 1'b0;
            end
            if (in_valid) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_cyc  = N;
                    ref_result(softmax_in, e_idx, e_conf, e_marg);
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("result_valid", result_valid, m_hold);
        chk("overrun_err", overrun_err, m_ovr);
        if (m_hold) begin
            chk("class_idx", class_idx, e_idx);
            chk("confidence", confidence, e_conf);
            chk("low_conf", low_conf, e_conf < 16'h0080);
            chk("margin", margin, e_marg);
        end else if (m_fresh) begin
            chk("idle_class_idx", class_idx, 0);
            chk("idle_confidence", confidence, 0);
            chk("idle_low_conf", low_conf, 0);
            chk("idle_margin", margin, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VW-1:0] v);
        softmax_in = v;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    // Cycles from the in_valid cycle until result_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 1;
        while (!result_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_idx"}, class_idx, 0);
        chk({tag, "_conf"}, confidence, 0);
        chk({tag, "_low"}, low_conf, 0);
        chk({tag, "_margin"}, margin, 0);
        chk({tag, "_ovr"}, overrun_err, 0);
    endtask

    logic [VW-1:0] va, vt;
    logic [3:0]    ri;
    logic [15:0]   rb, rm;
    int            lat;

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        result_ready = 1'b0;
        softmax_in   = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        va = {N{16'h0008}};
        va[0*DW +: DW] = 16'h0010;
        va[1*DW +: DW] = 16'h0020;
        va[2*DW +: DW] = 16'h00A0;
        vt = {N{16'h0010}};
        vt[3*DW +: DW] = 16'h0040;
        vt[7*DW +: DW] = 16'h0040;

        ref_result(va, ri, rb, rm);
        chk("pin_basic_idx", ri, 2);
        chk("pin_basic_conf", rb, 16'h00A0);
        chk("pin_basic_margin", rm, M_BASIC);
        ref_result(vt, ri, rb, rm);
        chk("pin_tie_idx", ri, 3);
        chk("pin_tie_margin", rm, 0);

        // Basic pick
        result_ready = 1'b1;
        send(va);
        wait_valid(lat);
        chk("basic_latency", lat, 11);
        chk("basic_idx", class_idx, 2);
        chk("basic_conf", confidence, 16'h00A0);
        chk("basic_low", low_conf, 0);
        chk("basic_margin", margin, M_BASIC);
        step();
        chk("basic_drop", result_valid, 0);

        // Tie and low confidence
        send(vt);
        wait_valid(lat);
        chk("tie_idx", class_idx, 3);
        chk("tie_conf", confidence, 16'h0040);
        chk("tie_low", low_conf, 1);
        chk("tie_margin", margin, 0);
        step();

        // Backpressure and overrun
        result_ready = 1'b0;
        send(va);
        repeat (14) step();
        softmax_in = vt;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
        chk("ovr_set", overrun_err, 1);
        repeat (4) step();
        chk("bp_valid", result_valid, 1);
        chk("bp_idx", class_idx, 2);
        chk("bp_conf", confidence, 16'h00A0);
        result_ready = 1'b1;
        step();
        chk("bp_drop", result_valid, 0);
        repeat (3) step();
        chk("ovr_sticky", overrun_err, 1);

        // Back-to-back
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clears_ovr", overrun_err, 0);
        result_ready = 1'b0;
        send(vt);
        wait_valid(lat);
        chk("b2b_first_idx", class_idx, 3);
        result_ready = 1'b1;
        send(va);
        chk("b2b_drop", result_valid, 0);
        wait_valid(lat);
        chk("b2b_latency", lat, 11);
        chk("b2b_idx", class_idx, 2);
        chk("b2b_ovr", overrun_err, 0);
        step();

        // All-zero vector
        send('0);
        wait_valid(lat);
        chk("zero_idx", class_idx, 0);
        chk("zero_conf", confidence, 0);
        chk("zero_low", low_conf, 1);
        chk("zero_margin", margin, 0);
        step();

        // Reset mid-SCAN
        send(va);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("midscan");
        send(vt);
        wait_valid(lat);
        chk("post_rst_latency", lat, 11);
        chk("post_rst_idx", class_idx, 3);
        step();

        // Randomized traffic
        repeat (400) begin
            rst          = ($urandom_range(0, 149) == 0);
            in_valid     = ($urandom_range(0, 5) == 0);
            softmax_in   = rand_vec();
            result_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst          = 1'b0;
        in_valid     = 1'b0;
        result_ready = 1'b1;
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
